// File: rtl/axis_frame_buffer.sv
// Store-and-forward AXI-Stream frame buffer.
// Bad or overflowing frames are discarded whole; only complete good frames egress.
module axis_frame_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
) (
    input  logic              axis_aclk,
    input  logic              axis_aresetn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    input  logic              drop_bad,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [15:0]       frames_ok,
    output logic [15:0]       frames_drop,
    output logic [ADDR_W-1:0] level
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int EW    = DATA_W + 1;
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DISCARD
    } wstate_t;

    wstate_t           state, state_n;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
    logic [ADDR_W-1:0] wr_commit, wr_commit_n;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr_inc;
    logic              tready_r;
    logic              beat;
    logic              full;
    logic              we;
    logic              ok_inc;
    logic              drop_inc;

    logic [EW-1:0]     mem [DEPTH];
    logic [EW-1:0]     rd_q;
    logic              pend;
    logic [EW-1:0]     e0, e1;
    logic [1:0]        occ;
    logic [1:0]        occ_left;
    logic              pop;
    logic              issue;

    assign s_axis_tready = tready_r;
    assign beat          = s_axis_tvalid & tready_r;
    assign wr_ptr_inc    = wr_ptr + ONE;
    assign full          = (wr_ptr_inc == rd_ptr);
    assign level         = wr_commit - rd_ptr;

    always_comb begin
        state_n     = state;
        wr_ptr_n    = wr_ptr;
        wr_commit_n = wr_commit;
        we          = 1'b0;
        ok_inc      = 1'b0;
        drop_inc    = 1'b0;
        unique case (state)
            IDLE, WRITE: begin
                if (beat) begin
                    if (full) begin
                        wr_ptr_n = wr_commit;
                        if (s_axis_tlast) begin
                            drop_inc = 1'b1;
                            state_n  = IDLE;
                        end else begin
                            state_n = DISCARD;
                        end
                    end else begin
                        we       = 1'b1;
                        wr_ptr_n = wr_ptr_inc;
                        if (s_axis_tlast) begin
                            state_n = IDLE;
                            if (s_axis_tuser && drop_bad) begin
                                wr_ptr_n = wr_commit;
                                drop_inc = 1'b1;
                            end else begin
                                wr_commit_n = wr_ptr_inc;
                                ok_inc      = 1'b1;
                            end
                        end else begin
                            state_n = WRITE;
                        end
                    end
                end
            end
            DISCARD: begin
                if (beat && s_axis_tlast) begin
                    drop_inc = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            wr_commit   <= '0;
            tready_r    <= 1'b0;
            frames_ok   <= '0;
            frames_drop <= '0;
        end else begin
            state     <= state_n;
            wr_ptr    <= wr_ptr_n;
            wr_commit <= wr_commit_n;
            tready_r  <= 1'b1;
            if (ok_inc && frames_ok != 16'hFFFF)
                frames_ok <= frames_ok + 16'd1;
            if (drop_inc && frames_drop != 16'hFFFF)
                frames_drop <= frames_drop + 16'd1;
        end
    end

    // Plain RAM: no reset so it maps onto block memory.
    always_ff @(posedge axis_aclk) begin
        if (we)
            mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
        if (issue)
            rd_q <= mem[rd_ptr];
    end

    // Output stage holds at most two beats counting the read in flight.
    assign pop      = (occ != 2'd0) & m_axis_tready;
    assign occ_left = occ - {1'b0, pop};
    assign issue    = (rd_ptr != wr_commit) &&
                      ((occ_left + {1'b0, pend}) < 2'd2);

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            rd_ptr <= '0;
            pend   <= 1'b0;
            e0     <= '0;
            e1     <= '0;
            occ    <= '0;
        end else begin
            pend <= issue;
            if (issue)
                rd_ptr <= rd_ptr + ONE;
            if (pop)
                e0 <= e1;
            if (pend) begin
                if (occ_left == 2'd0)
                    e0 <= rd_q;
                else
                    e1 <= rd_q;
            end
            occ <= occ_left + {1'b0, pend};
        end
    end

    assign m_axis_tvalid = (occ != 2'd0);
    assign m_axis_tdata  = e0[DATA_W-1:0];
    assign m_axis_tlast  = e0[DATA_W];

endmodule

// File: tb/tb_axis_frame_buffer.sv
// Randomized scoreboard bench for axis_frame_buffer.
// Small buffer (ADDR_W=4) so overflow and pointer wrap are reached quickly.
module tb_axis_frame_buffer;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int CAP = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic          s_tuser = 1'b0;
    logic          drop_bad = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic [15:0]   frames_ok;
    logic [15:0]   frames_drop;
    logic [AW-1:0] level;

    int            vectors = 0;
    int            miscompares = 0;
    int            exp_ok = 0;
    int            exp_drop = 0;
    int            ready_pct = 100;
    logic [DW:0]   exp_q[$];

    always #4 clk = ~clk;

    axis_frame_buffer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .axis_aclk     (clk),
        .axis_aresetn  (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .drop_bad      (drop_bad),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .frames_ok     (frames_ok),
        .frames_drop   (frames_drop),
        .level         (level)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Egress ready pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Monitor: a handshake seen at the negedge completes on the next posedge.
    initial begin
        logic        prev_stall;
        logic [DW:0] prev_beat;
        logic [DW:0] e;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("hold", 64'({m_tvalid, m_tlast, m_tdata}),
                          64'({1'b1, prev_beat}));
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL extra beat: got %0h want none",
                                 {m_tlast, m_tdata});
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 64'({m_tlast, m_tdata}), 64'(e));
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                prev_beat  = {m_tlast, m_tdata};
            end
        end
    end

    task automatic drive(input logic [DW-1:0] d, input logic l,
                         input logic u);
        s_tdata  = d;
        s_tlast  = l;
        s_tuser  = u;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: a frame survives iff it fits the buffer and is not a
    // flagged frame while drop_bad is set. Waiting until the beats still
    // owed downstream plus this frame fit guarantees no overflow.
    task automatic send_frame(input int len, input bit user,
                              input bit dbad, input bit seq);
        logic [DW:0]   beats[$];
        logic [DW-1:0] d;
        logic          l;
        logic          u;
        bit            dropped;
        int            w;
        dropped = (len > CAP) || (user && dbad);
        if (!dropped) begin
            w = 0;
            while (exp_q.size() + len > CAP && w < 3000) begin
                idle(1);
                w++;
            end
            if (w >= 3000)
                check("space wait", 64'(exp_q.size()), 64'(CAP - len));
        end
        drop_bad = dbad;
        for (int i = 0; i < len; i++) begin
            d = seq ? 8'(i) : 8'($urandom);
            l = (i == len - 1);
            u = l ? user : 1'($urandom);
            drive(d, l, u);
            beats.push_back({l, d});
        end
        if (dropped) begin
            exp_drop++;
        end else begin
            exp_ok++;
            foreach (beats[k]) exp_q.push_back(beats[k]);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            idle(1);
            n++;
        end
        check({tag, " drained"}, 64'(exp_q.size()), 64'(0));
        idle(4);
        check({tag, " idle"}, 64'(m_tvalid), 64'(0));
        check({tag, " frames_ok"}, 64'(frames_ok), 64'(exp_ok));
        check({tag, " frames_drop"}, 64'(frames_drop), 64'(exp_drop));
        check({tag, " level"}, 64'(level), 64'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        exp_q.delete();
        exp_ok = 0;
        exp_drop = 0;
        #1;
        check("reset outputs",
              64'({s_tready, m_tvalid, m_tlast, m_tdata,
                   frames_ok, frames_drop, level}), 64'(0));
        idle(3);
        rst_n = 1'b1;
        #1;
        check("tready before edge", 64'(s_tready), 64'(0));
        idle(1);
        check("tready after edge", 64'(s_tready), 64'(1));
    endtask

    initial begin
        idle(1);
        do_reset();

        // Latency and level peak on an empty buffer.
        ready_pct = 100;
        send_frame(12, 1'b0, 1'b0, 1'b1);
        check("level peak 12", 64'(level), 64'(12));
        check("latency +0", 64'(m_tvalid), 64'(0));
        idle(1);
        check("latency +1", 64'(m_tvalid), 64'(0));
        idle(1);
        check("latency +2", 64'({m_tvalid, m_tlast, m_tdata}),
              64'({1'b1, 1'b0, 8'h00}));
        drain("latency");

        // Capacity boundaries: 64 and 16 beats overflow, 15 fits.
        send_frame(64, 1'b0, 1'b0, 1'b1);
        send_frame(16, 1'b0, 1'b0, 1'b1);
        drain("overflow");
        send_frame(15, 1'b0, 1'b0, 1'b1);
        drain("exact fit");

        // Bad-frame handling.
        send_frame(10, 1'b1, 1'b1, 1'b0);
        drain("bad dropped");
        send_frame(10, 1'b1, 1'b0, 1'b0);
        send_frame(10, 1'b0, 1'b1, 1'b0);
        drain("bad kept");

        // Oversized frame followed by a good one.
        send_frame(20, 1'b0, 1'b0, 1'b0);
        send_frame(10, 1'b0, 1'b0, 1'b1);
        check("level peak 10", 64'(level), 64'(10));
        drain("20 then 10");

        // Back-to-back frames with stalling egress.
        ready_pct = 50;
        send_frame(5, 1'b0, 1'b0, 1'b0);
        send_frame(1, 1'b0, 1'b0, 1'b0);
        send_frame(9, 1'b0, 1'b0, 1'b0);
        drain("5-1-9");

        // Single-beat frames wrap every pointer many times.
        ready_pct = 100;
        for (int i = 0; i < 100; i++)
            send_frame(1, 1'b0, 1'b0, 1'b0);
        drain("single beats");

        // Random mix.
        ready_pct = 50;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0)
                send_frame($urandom_range(16, 20), 1'($urandom),
                           1'($urandom), 1'b0);
            else
                send_frame($urandom_range(1, 9), 1'($urandom),
                           1'($urandom), 1'b0);
            if ($urandom_range(0, 3) == 0)
                idle($urandom_range(1, 3));
        end
        drain("random");

        // Reset during the second frame while the first is egressing.
        ready_pct = 100;
        send_frame(12, 1'b0, 1'b0, 1'b0);
        drive(8'hA1, 1'b0, 1'b0);
        drive(8'hA2, 1'b0, 1'b0);
        drive(8'hA3, 1'b0, 1'b0);
        do_reset();
        drain("after reset");
        send_frame(4, 1'b0, 1'b0, 1'b0);
        drain("post reset frame");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
